// File: rtl/bit_select_sequential.sv
// Bit select unit: returns the index of the (k+1)-th set bit of a word,
// counting from the LSB. The word is scanned one nibble per clock while a
// residual rank is decremented by each nibble's population count.
module bit_select_sequential #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_WIDTH-1:0]         operand_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] rank_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [$clog2(DATA_WIDTH)-1:0] position_o,
  output logic                          found_o,
  output logic                          valid_o,
  input  logic                          ready_i
);

  localparam int NIBBLES_NUMBER = DATA_WIDTH / 4;
  localparam int RW = $clog2(DATA_WIDTH);
  localparam int IW = $clog2(NIBBLES_NUMBER);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES_NUMBER - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] op_q;
  logic [RW-1:0]         residual;
  logic [IW-1:0]         idx;
  logic [RW-1:0]         position;
  logic                  found;
  logic                  valid;

  logic [3:0]            nibble;
  logic [2:0]            nib_count;
  logic [RW-1:0]         nib_count_ext;
  logic [1:0]            hit_offset;

  // Number of set bits in a nibble (0..4).
  function automatic logic [2:0] popcount4(input logic [3:0] nib);
    popcount4 = {2'b00, nib[0]} + {2'b00, nib[1]} + {2'b00, nib[2]} + {2'b00, nib[3]};
  endfunction

  // Offset inside a nibble of its (r+1)-th set bit; only meaningful when r < popcount.
  function automatic logic [1:0] nib_select(input logic [3:0] nib, input logic [1:0] r);
    logic [2:0] seen;
    logic [1:0] off;
    seen = 3'd0;
    off  = 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (nib[b]) begin
        if (seen == {1'b0, r}) begin
          off = b[1:0];
        end else begin
          off = off;
        end
        seen = seen + 3'd1;
      end else begin
        seen = seen;
      end
    end
    nib_select = off;
  endfunction

  // Nibble currently under inspection and its contribution to the rank.
  always_comb begin
    nibble        = op_q[{idx, 2'b00} +: 4];
    nib_count     = popcount4(nibble);
    nib_count_ext = RW'(nib_count);
    hit_offset    = nib_select(nibble, residual[1:0]);
  end

  // Control FSM with registered result and valid; a hit ends the scan early,
  // otherwise the last nibble always terminates it with found cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      op_q     <= {DATA_WIDTH{1'b0}};
      residual <= {RW{1'b0}};
      idx      <= {IW{1'b0}};
      position <= {RW{1'b0}};
      found    <= 1'b0;
      valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            op_q     <= operand_i;
            residual <= rank_i;
            idx      <= {IW{1'b0}};
            state    <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          if (residual < nib_count_ext) begin
            position <= {idx, hit_offset};
            found    <= 1'b1;
            valid    <= 1'b1;
            state    <= DONE;
          end else if (idx == LAST_IDX) begin
            position <= {RW{1'b0}};
            found    <= 1'b0;
            valid    <= 1'b1;
            state    <= DONE;
          end else begin
            residual <= residual - nib_count_ext;
            idx      <= idx + IDX_ONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid <= 1'b0;
            state <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready_o    = (state == IDLE);
  assign position_o = position;
  assign found_o    = found;
  assign valid_o    = valid;

endmodule

// File: tb/tb_bit_select_sequential.sv
// Directed bench for bit_select_sequential (DATA_WIDTH = 32).
module tb_bit_select_sequential;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] operand_i;
  logic [4:0]  rank_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  position_o;
  logic        found_o;
  logic        valid_o;
  logic        ready_i;

  int n_cmp = 0;
  int n_err = 0;

  bit_select_sequential #(.DATA_WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .operand_i  (operand_i),
    .rank_i     (rank_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .position_o (position_o),
    .found_o    (found_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for valid_o; returns number of edges since the accept edge.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_i); #1;
      lat = i;
      if (valid_o) break;
    end
    if (!valid_o) lat = 99;
  endtask

  // Called at posedge+1: issue request, check latency/result, then handshake it out.
  task automatic do_req(input string tag, input logic [31:0] op, input logic [4:0] k,
                        input logic exp_found, input logic [4:0] exp_pos, input int exp_lat);
    int lat;
    check({tag, "_idle_ready"}, {31'd0, ready_o}, 32'd1);
    operand_i = op;
    rank_i    = k;
    valid_i   = 1'b1;
    @(posedge clk_i); #1;
    valid_i   = 1'b0;
    operand_i = ~op;
    rank_i    = ~k;
    check({tag, "_busy"}, {31'd0, ready_o}, 32'd0);
    wait_result(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_found"}, {31'd0, found_o}, {31'd0, exp_found});
    check({tag, "_pos"}, {27'd0, position_o}, {27'd0, exp_pos});
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check({tag, "_vdrop"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, ready_o}, 32'd1);
  endtask

  initial begin
    int lat;
    rst_i     = 1'b1;
    operand_i = 32'd0;
    rank_i    = 5'd0;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    #2;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_found", {31'd0, found_o}, 32'd0);
    check("rst_pos", {27'd0, position_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    do_req("t1", 32'h0000_0001, 5'd0, 1'b1, 5'd0, 1);
    do_req("t2a", 32'h8000_0000, 5'd0, 1'b1, 5'd31, 8);
    do_req("t2b", 32'h8000_0000, 5'd1, 1'b0, 5'd0, 8);
    do_req("t3a", 32'hA5A5_A5A5, 5'd9, 1'b1, 5'd18, 5);
    do_req("t3b", 32'hFFFF_FFFF, 5'd31, 1'b1, 5'd31, 8);
    do_req("t4a", 32'h0000_00F0, 5'd4, 1'b0, 5'd0, 8);
    do_req("t4b", 32'h0000_0000, 5'd0, 1'b0, 5'd0, 8);
    do_req("t4c", 32'h0000_00F0, 5'd3, 1'b1, 5'd7, 2);
    do_req("t4d", 32'h0001_0100, 5'd1, 1'b1, 5'd16, 5);
    do_req("t4e", 32'hFFFF_FFFE, 5'd31, 1'b0, 5'd0, 8);

    // Backpressure: result pending while a new request waits on valid_i.
    operand_i = 32'h0000_0030;
    rank_i    = 5'd0;
    valid_i   = 1'b1;
    @(posedge clk_i); #1;
    operand_i = 32'h0000_0003;
    rank_i    = 5'd1;
    wait_result(lat);
    check("t5_lat", lat, 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      check("t5_hold_valid", {31'd0, valid_o}, 32'd1);
      check("t5_hold_pos", {27'd0, position_o}, 32'd4);
      check("t5_hold_found", {31'd0, found_o}, 32'd1);
      check("t5_hold_ready", {31'd0, ready_o}, 32'd0);
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check("t5_hs_valid", {31'd0, valid_o}, 32'd0);
    check("t5_hs_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    check("t5_accept", {31'd0, ready_o}, 32'd0);
    wait_result(lat);
    check("t5_new_lat", lat, 32'd1);
    check("t5_new_pos", {27'd0, position_o}, 32'd1);
    check("t5_new_found", {31'd0, found_o}, 32'd1);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;

    // Reset pulsed mid-scan; previous result (found=1,pos=1) is still registered.
    operand_i = 32'h8000_0000;
    rank_i    = 5'd0;
    valid_i   = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    check("t6_valid", {31'd0, valid_o}, 32'd0);
    check("t6_found", {31'd0, found_o}, 32'd0);
    check("t6_pos", {27'd0, position_o}, 32'd0);
    check("t6_ready", {31'd0, ready_o}, 32'd1);
    #3;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("t6_no_result", {31'd0, valid_o}, 32'd0);
    do_req("t6_after", 32'hA5A5_A5A5, 5'd9, 1'b1, 5'd18, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
